// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the RV32IM fetch stage: PC type, bubble encoding,
// fetch FSM state codes and the instruction/PC+4 pair presented to IF/ID.
package instruction_fetch_unit_pkg;

  localparam int unsigned PC_WIDTH = 32;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSTRUCTION = 32'h00000013;

  localparam logic [1:0] S_FETCH   = 2'd0;
  localparam logic [1:0] S_HOLD    = 2'd1;
  localparam logic [1:0] S_DISCARD = 2'd2;

  typedef logic [PC_WIDTH-1:0] pc_t;

  typedef struct packed {
    logic [31:0] instruction;
    pc_t         pc_plus_4;
  } fetch_pair_t;

  function automatic pc_t align_word(input pc_t addr);
    return addr & ~pc_t'(3);
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction memory read port with busy-wait handshake.
interface instruction_fetch_unit_if;
  import instruction_fetch_unit_pkg::*;

  logic        IMEM_READ;
  pc_t         IMEM_ADDR;
  logic [31:0] IMEM_READDATA;
  logic        IMEM_BUSYWAIT;

  modport master (
    output IMEM_READ,
    output IMEM_ADDR,
    input  IMEM_READDATA,
    input  IMEM_BUSYWAIT
  );

  modport slave (
    input  IMEM_READ,
    input  IMEM_ADDR,
    output IMEM_READDATA,
    output IMEM_BUSYWAIT
  );
endinterface

// File: rtl/instruction_fetch_unit_fetch_hold_buffer.sv
// One-entry holding register for a word fetched while IF/ID is stalled.
// Reset and clear both return it to the bubble pair {NOP, 0}.
module instruction_fetch_unit_fetch_hold_buffer
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTRUCTION
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        load,
  input  logic        clear,
  input  fetch_pair_t load_pair,
  output fetch_pair_t pair
);

  fetch_pair_t pair_q;

  always_ff @(posedge CLK) begin
    if (RESET || clear) begin
      pair_q <= {NOP_INSTR, pc_t'(0)};
    end else if (load) begin
      pair_q <= load_pair;
    end
  end

  assign pair = pair_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, drives the instruction memory port, applies
// redirects and parks a stalled word in the hold buffer so nothing is lost.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h00000000,
  parameter logic [31:0] NOP_INSTR = NOP_INSTRUCTION
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       STALL,
  input  logic                       BRANCH_TAKEN,
  input  pc_t                        BRANCH_TARGET,
  instruction_fetch_unit_if.master   imem,
  output logic [31:0]                OUT_INSTRUCTION,
  output pc_t                        OUT_PC_PLUS_4,
  output logic                       IF_ID_ENABLE
);

  logic [1:0]  state_q, state_d;
  pc_t         pc_q, pc_d;
  pc_t         redirect_pc_q, redirect_pc_d;
  pc_t         target;
  pc_t         pc_plus_4;
  logic        mem_ready;
  logic        buf_load, buf_clear;
  fetch_pair_t buf_pair;
  fetch_pair_t out_pair;

  assign target    = align_word(BRANCH_TARGET);
  assign pc_plus_4 = pc_q + pc_t'(4);
  assign mem_ready = ~imem.IMEM_BUSYWAIT;

  // Read request and address depend on registered state only.
  assign imem.IMEM_READ = (state_q != S_HOLD);
  assign imem.IMEM_ADDR = pc_q;

  // A redirect must squash the wrong-path slot even while IF/ID is stalled.
  assign IF_ID_ENABLE    = BRANCH_TAKEN | ~STALL;
  assign OUT_INSTRUCTION = out_pair.instruction;
  assign OUT_PC_PLUS_4   = out_pair.pc_plus_4;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    redirect_pc_d = redirect_pc_q;
    buf_load      = 1'b0;
    buf_clear     = 1'b0;
    out_pair      = {NOP_INSTR, pc_t'(0)};

    case (state_q)
      S_FETCH: begin
        if (BRANCH_TAKEN) begin
          if (mem_ready) begin
            pc_d = target;
          end else begin
            redirect_pc_d = target;
            state_d       = S_DISCARD;
          end
        end else if (mem_ready) begin
          pc_d = pc_plus_4;
          if (STALL) begin
            buf_load = 1'b1;
            state_d  = S_HOLD;
          end else begin
            out_pair = {imem.IMEM_READDATA, pc_plus_4};
          end
        end
      end

      S_HOLD: begin
        if (BRANCH_TAKEN) begin
          pc_d      = target;
          buf_clear = 1'b1;
          state_d   = S_FETCH;
        end else begin
          out_pair = buf_pair;
          if (!STALL) begin
            buf_clear = 1'b1;
            state_d   = S_FETCH;
          end
        end
      end

      S_DISCARD: begin
        // Newest redirect wins; the in-flight word is dropped on completion.
        if (BRANCH_TAKEN) begin
          redirect_pc_d = target;
        end
        if (mem_ready) begin
          pc_d    = BRANCH_TAKEN ? target : redirect_pc_q;
          state_d = S_FETCH;
        end
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q       <= S_FETCH;
      pc_q          <= RESET_PC;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  instruction_fetch_unit_fetch_hold_buffer #(
    .NOP_INSTR (NOP_INSTR)
  ) u_hold_buffer (
    .CLK       (CLK),
    .RESET     (RESET),
    .load      (buf_load),
    .clear     (buf_clear),
    .load_pair ({imem.IMEM_READDATA, pc_plus_4}),
    .pair      (buf_pair)
  );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus a randomized run
// checked against a transaction-level model of the fetch stage.
module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        STALL;
  logic        BRANCH_TAKEN;
  logic [31:0] BRANCH_TARGET;
  logic [31:0] OUT_INSTRUCTION;
  logic [31:0] OUT_PC_PLUS_4;
  logic        IF_ID_ENABLE;

  instruction_fetch_unit_if imem_bus ();

  instruction_fetch_unit #(
    .RESET_PC  (32'h00000000),
    .NOP_INSTR (NOP)
  ) dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .STALL           (STALL),
    .BRANCH_TAKEN    (BRANCH_TAKEN),
    .BRANCH_TARGET   (BRANCH_TARGET),
    .imem            (imem_bus),
    .OUT_INSTRUCTION (OUT_INSTRUCTION),
    .OUT_PC_PLUS_4   (OUT_PC_PLUS_4),
    .IF_ID_ENABLE    (IF_ID_ENABLE)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Memory contents: a hash of the address unless overridden.
  logic [31:0] mem_over [logic [31:0]];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_over.exists(a)) return mem_over[a];
    return (a * 32'h9E3779B1) ^ 32'hC0DE0013;
  endfunction

  // Reference model: next fetch address, a queue of at most one parked word,
  // and a pending redirect waiting for an abandoned read to complete.
  logic [31:0] m_pc = '0;
  logic [31:0] m_redir = '0;
  bit          m_discard = 1'b0;
  logic [63:0] m_held [$];

  logic        exp_read, exp_en, obs_read, obs_en;
  logic [31:0] exp_addr, exp_instr, exp_pc4, obs_addr, obs_instr, obs_pc4;

  task automatic run_cycle(input logic rst, input logic stall, input logic bt,
                           input logic [31:0] tgt, input logic busy);
    logic [31:0] t;
    t = {tgt[31:2], 2'b00};
    RESET         = rst;
    STALL         = stall;
    BRANCH_TAKEN  = bt;
    BRANCH_TARGET = tgt;
    imem_bus.IMEM_BUSYWAIT = busy;
    imem_bus.IMEM_READDATA = busy ? $urandom() : mem_word(imem_bus.IMEM_ADDR);

    exp_read = (m_held.size() == 0);
    exp_addr = m_pc;
    exp_en   = bt | ~stall;
    if (bt) {exp_instr, exp_pc4} = {NOP, 32'h0};
    else if (m_held.size() != 0) {exp_instr, exp_pc4} = m_held[0];
    else if (!m_discard && !busy && !stall) {exp_instr, exp_pc4} = {mem_word(m_pc), m_pc + 32'd4};
    else {exp_instr, exp_pc4} = {NOP, 32'h0};

    @(negedge CLK);
    obs_read  = imem_bus.IMEM_READ;
    obs_addr  = imem_bus.IMEM_ADDR;
    obs_instr = OUT_INSTRUCTION;
    obs_pc4   = OUT_PC_PLUS_4;
    obs_en    = IF_ID_ENABLE;
    @(posedge CLK);

    if (rst) begin
      m_pc = 32'h0; m_redir = 32'h0; m_discard = 1'b0; m_held.delete();
    end else if (m_held.size() != 0) begin
      if (bt) begin m_pc = t; m_held.delete(); end
      else if (!stall) m_held.delete();
    end else if (m_discard) begin
      if (bt) m_redir = t;
      if (!busy) begin m_pc = m_redir; m_discard = 1'b0; end
    end else if (bt) begin
      if (busy) begin m_discard = 1'b1; m_redir = t; end
      else m_pc = t;
    end else if (!busy) begin
      if (stall) m_held.push_back({mem_word(m_pc), m_pc + 32'd4});
      m_pc = m_pc + 32'd4;
    end
    #1;
  endtask

  task automatic test_reset();
    run_cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    run_cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checks++; if (obs_read !== 1'b1) begin errors++; $display("FAIL reset_read: got %b expected 1", obs_read); end
    checks++; if (obs_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 00000000", obs_addr); end
    checks++; if (obs_pc4 !== 32'h4) begin errors++; $display("FAIL reset_pc4: got %h expected 00000004", obs_pc4); end
    checks++; if (obs_instr !== mem_word(32'h0)) begin errors++; $display("FAIL reset_instr: got %h expected %h", obs_instr, mem_word(32'h0)); end
  endtask

  task automatic test_sequential();
    for (int i = 1; i < 4; i++) begin
      run_cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      checks++; if (obs_addr !== 32'(4 * i)) begin errors++; $display("FAIL seq_addr: got %h expected %h", obs_addr, 32'(4 * i)); end
      checks++; if (obs_pc4 !== 32'(4 * i + 4)) begin errors++; $display("FAIL seq_pc4: got %h expected %h", obs_pc4, 32'(4 * i + 4)); end
      checks++; if (obs_en !== 1'b1) begin errors++; $display("FAIL seq_enable: got %b expected 1", obs_en); end
    end
  endtask

  task automatic test_busywait();
    run_cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    run_cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    run_cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      run_cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      checks++; if ({obs_instr, obs_pc4} !== {NOP, 32'h0}) begin errors++; $display("FAIL busy_bubble: got %h/%h expected %h/0", obs_instr, obs_pc4, NOP); end
      checks++; if (obs_addr !== 32'h8) begin errors++; $display("FAIL busy_addr: got %h expected 00000008", obs_addr); end
    end
    run_cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checks++; if ({obs_instr, obs_pc4} !== {mem_word(32'h8), 32'hC}) begin errors++; $display("FAIL busy_release: got %h/%h expected %h/0000000c", obs_instr, obs_pc4, mem_word(32'h8)); end
    run_cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checks++; if (obs_addr !== 32'hC) begin errors++; $display("FAIL busy_next_addr: got %h expected 0000000c", obs_addr); end
  endtask

  task automatic test_stall();
    mem_over[32'h10] = 32'hAABBCCDD;
    run_cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    checks++; if (obs_en !== 1'b0) begin errors++; $display("FAIL stall_enable: got %b expected 0", obs_en); end
    checks++; if (obs_addr !== 32'h10) begin errors++; $display("FAIL stall_addr: got %h expected 00000010", obs_addr); end
    run_cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    checks++; if (obs_read !== 1'b0) begin errors++; $display("FAIL hold_read: got %b expected 0", obs_read); end
    checks++; if (obs_en !== 1'b0) begin errors++; $display("FAIL hold_enable: got %b expected 0", obs_en); end
    run_cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checks++; if ({obs_instr, obs_pc4} !== {32'hAABBCCDD, 32'h14}) begin errors++; $display("FAIL hold_release: got %h/%h expected aabbccdd/00000014", obs_instr, obs_pc4); end
    checks++; if (obs_en !== 1'b1) begin errors++; $display("FAIL release_enable: got %b expected 1", obs_en); end
    run_cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checks++; if (obs_addr !== 32'h14 || obs_read !== 1'b1) begin errors++; $display("FAIL release_next: got %b/%h expected 1/00000014", obs_read, obs_addr); end
  endtask

  task automatic test_branch_busy();
    logic [31:0] final_tgt;
    for (int pass = 0; pass < 2; pass++) begin
      final_tgt = (pass == 0) ? 32'h100 : 32'h200;
      run_cycle(1'b0, 1'b0, 1'b1, 32'h20, 1'b0);
      checks++; if ({obs_instr, obs_pc4} !== {NOP, 32'h0}) begin errors++; $display("FAIL branch_bubble: got %h/%h expected %h/0", obs_instr, obs_pc4, NOP); end
      run_cycle(1'b0, 1'b0, 1'b1, 32'h100, 1'b1);
      checks++; if (obs_addr !== 32'h20) begin errors++; $display("FAIL branch_busy_addr: got %h expected 00000020", obs_addr); end
      run_cycle(1'b0, 1'b0, pass == 1, 32'h200, 1'b1);
      checks++; if (obs_addr !== 32'h20) begin errors++; $display("FAIL discard_addr: got %h expected 00000020", obs_addr); end
      run_cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      checks++; if ({obs_instr, obs_pc4} !== {NOP, 32'h0}) begin errors++; $display("FAIL discard_drop: got %h/%h expected %h/0", obs_instr, obs_pc4, NOP); end
      run_cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      checks++; if (obs_addr !== final_tgt) begin errors++; $display("FAIL discard_target: got %h expected %h", obs_addr, final_tgt); end
    end
  endtask

  task automatic test_hold_branch();
    run_cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    run_cycle(1'b0, 1'b1, 1'b1, 32'h103, 1'b0);
    checks++; if (obs_en !== 1'b1) begin errors++; $display("FAIL hold_branch_enable: got %b expected 1", obs_en); end
    checks++; if ({obs_instr, obs_pc4} !== {NOP, 32'h0}) begin errors++; $display("FAIL hold_branch_bubble: got %h/%h expected %h/0", obs_instr, obs_pc4, NOP); end
    run_cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checks++; if (obs_addr !== 32'h100) begin errors++; $display("FAIL hold_branch_addr: got %h expected 00000100", obs_addr); end
    checks++; if (obs_pc4 !== 32'h104) begin errors++; $display("FAIL hold_branch_dropped: got %h expected 00000104", obs_pc4); end
  endtask

  task automatic test_reset_midbusy();
    run_cycle(1'b0, 1'b0, 1'b1, 32'h40, 1'b0);
    run_cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    checks++; if (obs_addr !== 32'h40) begin errors++; $display("FAIL midbusy_addr: got %h expected 00000040", obs_addr); end
    run_cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    run_cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    checks++; if (obs_addr !== 32'h0 || obs_read !== 1'b1) begin errors++; $display("FAIL midbusy_reset: got %b/%h expected 1/00000000", obs_read, obs_addr); end
    checks++; if ({obs_instr, obs_pc4} !== {NOP, 32'h0}) begin errors++; $display("FAIL midbusy_bubble: got %h/%h expected %h/0", obs_instr, obs_pc4, NOP); end
  endtask

  task automatic test_wrap();
    run_cycle(1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0);
    run_cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checks++; if (obs_addr !== 32'hFFFFFFFC) begin errors++; $display("FAIL wrap_addr: got %h expected fffffffc", obs_addr); end
    checks++; if (obs_pc4 !== 32'h0) begin errors++; $display("FAIL wrap_pc4: got %h expected 00000000", obs_pc4); end
    run_cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checks++; if (obs_addr !== 32'h0) begin errors++; $display("FAIL wrap_next: got %h expected 00000000", obs_addr); end
  endtask

  task automatic test_random();
    logic rst, stall, bt, busy;
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(199) == 0);
      stall = ($urandom_range(99) < 25);
      bt    = ($urandom_range(99) < 10);
      busy  = ($urandom_range(99) < 30);
      run_cycle(rst, stall, bt, $urandom(), busy);
      checks++; if (obs_read !== exp_read) begin errors++; $display("FAIL rand_read @%0d: got %b expected %b", i, obs_read, exp_read); end
      checks++; if (obs_addr !== exp_addr) begin errors++; $display("FAIL rand_addr @%0d: got %h expected %h", i, obs_addr, exp_addr); end
      checks++; if (obs_instr !== exp_instr) begin errors++; $display("FAIL rand_instr @%0d: got %h expected %h", i, obs_instr, exp_instr); end
      checks++; if (obs_pc4 !== exp_pc4) begin errors++; $display("FAIL rand_pc4 @%0d: got %h expected %h", i, obs_pc4, exp_pc4); end
      checks++; if (obs_en !== exp_en) begin errors++; $display("FAIL rand_enable @%0d: got %b expected %b", i, obs_en, exp_en); end
    end
  endtask

  initial begin
    RESET = 1'b1; STALL = 1'b0; BRANCH_TAKEN = 1'b0; BRANCH_TARGET = '0;
    imem_bus.IMEM_BUSYWAIT = 1'b0; imem_bus.IMEM_READDATA = '0;
    test_reset();
    test_sequential();
    test_busywait();
    test_stall();
    test_branch_busy();
    test_hold_branch();
    test_reset_midbusy();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
